// File: rtl/rf_wr_arbiter_pkg.sv
// Shared register-file write types: write-request struct and index/enable widths.
// No logic and no latency; the struct is carried as-is by the FIFO and arbiter.
package rf_wr_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int BE_W      = 4;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [BE_W-1:0]      we;
        logic [REG_IDX_W-1:0] waddr;
        logic [DATA_W-1:0]    wdata;
    } wr_req_t;

    // r0 is hardwired and an all-zero enable writes nothing
    function automatic logic writes_reg(input wr_req_t r);
        return (r.we != '0) && (r.waddr != '0);
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester/arbiter bundle: port A, port B, register-file write port, hazard queries.
// master = requesters side, slave = arbiter side.
interface rf_wr_arbiter_if;
    import rf_wr_arbiter_pkg::*;

    logic                 a_valid;
    logic                 a_ready;
    logic [BE_W-1:0]      a_we;
    logic [REG_IDX_W-1:0] a_waddr;
    logic [DATA_W-1:0]    a_wdata;

    logic                 b_valid;
    logic                 b_ready;
    logic [BE_W-1:0]      b_we;
    logic [REG_IDX_W-1:0] b_waddr;
    logic [DATA_W-1:0]    b_wdata;

    logic [BE_W-1:0]      rf_we;
    logic [REG_IDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;

    logic [REG_IDX_W-1:0] q_addr1;
    logic [REG_IDX_W-1:0] q_addr2;
    logic                 q_busy1;
    logic                 q_busy2;

    modport master (
        output a_valid, a_we, a_waddr, a_wdata,
        output b_valid, b_we, b_waddr, b_wdata,
        output q_addr1, q_addr2,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  q_busy1, q_busy2
    );

    modport slave (
        input  a_valid, a_we, a_waddr, a_wdata,
        input  b_valid, b_we, b_waddr, b_wdata,
        input  q_addr1, q_addr2,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata,
        output q_busy1, q_busy2
    );

endinterface

// File: rtl/rf_wr_fifo.sv
// Port-B write buffer; a pushed entry is visible at the head one cycle after the push.
// full/empty come straight from registered occupancy; push-when-full/pop-when-empty are ignored.
module rf_wr_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wr_req_t                push_dat,
    input  logic                   pop,
    output wr_req_t                head_dat,
    output logic                   full,
    output logic                   empty,
    output wr_req_t [DEPTH-1:0]    ent_dat,
    output logic    [DEPTH-1:0]    ent_vld
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                do_push, do_pop;
    logic [PTR_W-1:0]    off;

    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q];
    assign ent_dat  = mem_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // A slot is live when its distance from the read pointer is below occupancy
    always_comb begin
        off     = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - rd_ptr_q;
            ent_vld[i] = (CNT_W'(off) < cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Two-port register-file write arbiter: A passes through in the same cycle, B is buffered (>=1 cycle).
// b_ready tracks buffer space only; a_ready drops for one cycle when the buffered head has starved.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    rf_wr_arbiter_if.slave    bus
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    wr_req_t                  a_req, b_req, head, grant_req;
    wr_req_t [FIFO_DEPTH-1:0] ent_dat;
    logic    [FIFO_DEPTH-1:0] ent_vld;
    logic                     fifo_full, fifo_empty;
    logic                     force_b, a_rdy, b_rdy, a_gnt, b_gnt, b_push;
    logic [SC_W-1:0]          starve_cnt_q, starve_cnt_d;
    logic [REG_IDX_W-1:0]     last_waddr_q, last_waddr_d;
    logic [DATA_W-1:0]        last_wdata_q, last_wdata_d;
    logic [BE_W-1:0]          rf_we;
    logic                     busy1, busy2;

    assign a_req = '{we: bus.a_we, waddr: bus.a_waddr, wdata: bus.a_wdata};
    assign b_req = '{we: bus.b_we, waddr: bus.b_waddr, wdata: bus.b_wdata};

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (b_push),
        .push_dat (b_req),
        .pop      (b_gnt),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ent_dat  (ent_dat),
        .ent_vld  (ent_vld)
    );

    always_comb begin
        force_b   = (starve_cnt_q == SC_W'(STARVE_LIMIT)) && !fifo_empty;
        a_rdy     = !reset && !force_b;
        b_rdy     = !reset && !fifo_full;
        a_gnt     = a_rdy && bus.a_valid;
        b_gnt     = !reset && !fifo_empty && (force_b || !bus.a_valid);
        b_push    = bus.b_valid && b_rdy;
        grant_req = a_gnt ? a_req : head;

        rf_we = '0;
        if ((a_gnt || b_gnt) && (grant_req.waddr != '0)) begin
            rf_we = grant_req.we;
        end

        // Address/data hold their last granted values between writes
        last_waddr_d = last_waddr_q;
        last_wdata_d = last_wdata_q;
        if (a_gnt || b_gnt) begin
            last_waddr_d = grant_req.waddr;
            last_wdata_d = grant_req.wdata;
        end

        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || b_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end
    end

    // Hazard lookup sees only entries already resident, not one being pushed now
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i] && writes_reg(ent_dat[i])) begin
                if (ent_dat[i].waddr == bus.q_addr1) busy1 = 1'b1;
                if (ent_dat[i].waddr == bus.q_addr2) busy2 = 1'b1;
            end
        end
        if (reset) begin
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            last_waddr_q <= '0;
            last_wdata_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            last_waddr_q <= last_waddr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    assign bus.a_ready  = a_rdy;
    assign bus.b_ready  = b_rdy;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = (a_gnt || b_gnt) ? grant_req.waddr : last_waddr_q;
    assign bus.rf_wdata = (a_gnt || b_gnt) ? grant_req.wdata : last_wdata_q;
    assign bus.q_busy1  = busy1;
    assign bus.q_busy2  = busy2;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: pass-through, buffering, starvation, back-pressure, r0, reset.
module tb_rf_wr_arbiter;
    import rf_wr_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    rf_wr_arbiter_if bus ();

    rf_wr_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [3:0] we, input logic [4:0] ad, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_we    = we;
        bus.a_waddr = ad;
        bus.a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic [3:0] we, input logic [4:0] ad, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_we    = we;
        bus.b_waddr = ad;
        bus.b_wdata = d;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        set_a(1'b1, 4'hF, 5'd5, 32'h55);
        set_b(1'b1, 4'hF, 5'd9, 32'h99);
        bus.q_addr1 = 5'd9;
        bus.q_addr2 = 5'd0;

        // Reset state with both requesters active
        tick();
        tick();
        check("rst_a_ready", bus.a_ready, 0);
        check("rst_b_ready", bus.b_ready, 0);
        check("rst_rf_we",   bus.rf_we,   0);
        check("rst_busy1",   bus.q_busy1, 0);
        set_b(1'b0, 4'h0, 5'd0, 32'h0);
        reset = 1'b0;
        #1;
        check("post_rst_a_ready", bus.a_ready, 1);
        check("post_rst_b_ready", bus.b_ready, 1);

        // A-only pass-through
        set_a(1'b1, 4'hF, 5'd5, 32'h12345678);
        #1;
        check("a_rf_we",    bus.rf_we,    4'hF);
        check("a_rf_waddr", bus.rf_waddr, 5);
        check("a_rf_wdata", bus.rf_wdata, 32'h12345678);
        check("a_ready",    bus.a_ready,  1);
        tick();
        set_a(1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        check("idle_rf_we",      bus.rf_we,    0);
        check("idle_hold_waddr", bus.rf_waddr, 5);
        check("idle_hold_wdata", bus.rf_wdata, 32'h12345678);

        // B-only: pushed at edge N, written in N+1, busy only in N+1
        set_b(1'b1, 4'h3, 5'd7, 32'h0000BEEF);
        bus.q_addr1 = 5'd7;
        #1;
        check("b_push_ready", bus.b_ready, 1);
        check("b_push_busy",  bus.q_busy1, 0);
        check("b_push_rf_we", bus.rf_we,   0);
        tick();
        set_b(1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        check("b_rf_we",    bus.rf_we,    4'h3);
        check("b_rf_waddr", bus.rf_waddr, 7);
        check("b_rf_wdata", bus.rf_wdata, 32'h0000BEEF);
        check("b_busy_n1",  bus.q_busy1,  1);
        tick();
        check("b_busy_n2", bus.q_busy1, 0);
        check("b_rf_we_n2", bus.rf_we,  0);

        // Starvation: one buffered entry against continuous A
        set_a(1'b1, 4'hF, 5'd5, 32'h1);
        set_b(1'b1, 4'hF, 5'd9, 32'hA9);
        bus.q_addr1 = 5'd9;
        tick();
        set_b(1'b0, 4'h0, 5'd0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("starve_a_ready_c%0d", c), bus.a_ready,  (c != 4));
            check($sformatf("starve_wdata_c%0d", c),   bus.rf_wdata, (c == 4) ? 32'hA9 : 32'h1);
            check($sformatf("starve_busy_c%0d", c),    bus.q_busy1,  (c <= 4));
            tick();
        end

        // Back-pressure: two entries fill the buffer while A never lets go
        set_a(1'b1, 4'hF, 5'd6, 32'h66);
        set_b(1'b1, 4'hF, 5'd10, 32'h10);
        bus.q_addr1 = 5'd10;
        bus.q_addr2 = 5'd11;
        tick();
        set_b(1'b1, 4'hF, 5'd11, 32'h11);
        #1;
        check("full_b_ready_c1", bus.b_ready, 1);
        tick();
        set_b(1'b0, 4'h0, 5'd0, 32'h0);
        for (int c = 2; c <= 9; c++) begin
            #1;
            check($sformatf("full_b_ready_c%0d", c), bus.b_ready, (c >= 5));
            check($sformatf("full_a_ready_c%0d", c), bus.a_ready, !(c == 4 || c == 8));
            check($sformatf("full_wdata_c%0d", c),   bus.rf_wdata,
                  (c == 4) ? 32'h10 : ((c == 8) ? 32'h11 : 32'h66));
            check($sformatf("full_busy2_c%0d", c),   bus.q_busy2, (c <= 8));
            tick();
        end

        // r0 target and zero byte-enable: both drain, nothing written
        set_a(1'b0, 4'h0, 5'd0, 32'h0);
        set_b(1'b1, 4'hF, 5'd0, 32'hDEAD);
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd3;
        tick();
        set_b(1'b1, 4'h0, 5'd3, 32'hCAFE);
        #1;
        check("r0_rf_we",    bus.rf_we,    0);
        check("r0_rf_waddr", bus.rf_waddr, 0);
        check("r0_busy1",    bus.q_busy1,  0);
        tick();
        set_b(1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        check("we0_rf_we",    bus.rf_we,    0);
        check("we0_rf_waddr", bus.rf_waddr, 3);
        check("we0_rf_wdata", bus.rf_wdata, 32'hCAFE);
        check("we0_busy2",    bus.q_busy2,  0);
        tick();
        check("zero_drain_rf_we",   bus.rf_we,   0);
        check("zero_drain_b_ready", bus.b_ready, 1);

        // Reset with two buffered entries and starve count at 2
        set_a(1'b1, 4'hF, 5'd6, 32'h66);
        set_b(1'b1, 4'hF, 5'd20, 32'h20);
        bus.q_addr1 = 5'd20;
        bus.q_addr2 = 5'd21;
        tick();
        set_b(1'b1, 4'hF, 5'd21, 32'h21);
        tick();
        set_b(1'b0, 4'h0, 5'd0, 32'h0);
        tick();
        check("pre_rst_busy1",   bus.q_busy1, 1);
        check("pre_rst_busy2",   bus.q_busy2, 1);
        check("pre_rst_a_ready", bus.a_ready, 1);
        reset = 1'b1;
        tick();
        check("midrst_rf_we",   bus.rf_we,   0);
        check("midrst_a_ready", bus.a_ready, 0);
        check("midrst_b_ready", bus.b_ready, 0);
        check("midrst_busy1",   bus.q_busy1, 0);
        check("midrst_busy2",   bus.q_busy2, 0);
        reset = 1'b0;
        set_a(1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        check("postrst_b_ready", bus.b_ready, 1);
        check("postrst_busy1",   bus.q_busy1, 0);
        check("postrst_busy2",   bus.q_busy2, 0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("postrst_no_write_c%0d", c), bus.rf_we, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
